multi_timer: RTL
================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning main counter and limit width.
REQ-003 SHALL have parameter PRE_W, default 8, meaning prescaler width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  configuration write strobe, sampled each edge.
REQ-007 SHALL have port wr_ch  input  max(1,clog2(N_CH))  target channel of write.
REQ-008 SHALL have port wr_sel  input  2  target register: 0 = limit, 1 = prescale, 2 = ctrl, 3 = ignored.
REQ-009 SHALL have port wr_data  input  CNT_W  write data, LSB-aligned and truncated to the register width.
REQ-010 SHALL have port ack  input  N_CH  per-channel irq clear.
REQ-011 SHALL have port pulse  output  N_CH  per-channel timer output.
REQ-012 SHALL have port irq  output  N_CH  per-channel sticky terminal-event flag.
REQ-013 SHALL have port en_out  output  N_CH  per-channel current enable bit.

Function
REQ-014 Each channel SHALL hold the registers limit (CNT_W), prescale (PRE_W), ctrl[0] = enable, ctrl[2:1] = mode (00 periodic, 01 one-shot, 10 square, 11 treated as periodic), cnt (CNT_W) and pre (PRE_W).
REQ-015 A write to any register of a channel SHALL update that register and clear that channel's cnt and pre at the same edge; the channel's pulse SHALL go to 0 at that edge.
REQ-016 On each edge while the channel is enabled with no write to it: if pre == prescale, then pre <= 0 and a tick occurs; otherwise pre <= pre + 1.
REQ-017 On a tick: if cnt >= limit, a terminal event occurs and cnt <= 0; otherwise cnt <= cnt + 1. Arithmetic SHALL be unsigned and SHALL never wrap past limit.
REQ-018 Periodic mode: pulse SHALL be 1 for exactly the cycle following each terminal event. Period SHALL be (limit+1)*(prescale+1) cycles; with limit = 0 and prescale = 0, pulse SHALL stay constantly 1.
REQ-019 One-shot mode: the first terminal event SHALL produce the same one-cycle pulse and SHALL clear enable at the same edge; the counters then hold at 0.
REQ-020 Square mode: pulse SHALL toggle at each terminal event. Half-period SHALL be (limit+1)*(prescale+1) cycles.
REQ-021 Disabled channel: cnt and pre SHALL hold; pulse SHALL be 0 in periodic and one-shot modes and SHALL hold its level in square mode.
REQ-022 A terminal event SHALL set irq at the same edge. ack SHALL clear irq at the next edge. If set and ack occur on the same edge, set SHALL win.
REQ-023 Channels SHALL be fully independent; a write to one channel SHALL NOT affect any other channel.
REQ-024 A wr_ch value >= N_CH SHALL be ignored.

Reset
REQ-025 On reset at any time, including mid-count: cnt = 0, pre = 0, limit = all ones, prescale = 0, ctrl = 0, pulse = 0, irq = 0, en_out = 0, effective at that edge. Reset SHALL override wr_en and ack.

Structure
REQ-026 Shared package timer_pkg SHALL hold the mode encodings (MODE_PERIODIC, MODE_ONESHOT, MODE_SQUARE) and the wr_sel encodings (SEL_LIMIT, SEL_PRESCALE, SEL_CTRL).
REQ-027 The channel datapath SHALL be a sub-module timer_channel, instantiated N_CH times by generate; the top level SHALL contain only write decode and port fan-out.

Verification
REQ-028 Scenario: ch0 limit = 3, prescale = 0, ctrl = periodic + enable -> pulse[0] is 1 for one cycle, 4 edges after the ctrl write, then every 4 cycles; irq[0] is set.
REQ-029 Scenario: ch1 limit = 2, prescale = 1, one-shot + enable -> a single pulse[1] 6 edges after the write; en_out[1] is 0 afterwards; no further pulses over 50 cycles.
REQ-030 Scenario: ch2 limit = 4, prescale = 0, square + enable -> pulse[2] toggles every 5 cycles (period 10); after disable, the level holds.
REQ-031 Scenario: ack[0] asserted in the same cycle as a terminal event -> irq[0] remains 1; ack[0] alone -> irq[0] is 0 at the next edge.
REQ-032 Scenario: reset asserted mid-count on all channels -> all outputs are 0 after that edge; after re-enable, timing restarts from the count of REQ-028.
REQ-033 Scenario: limit = 0, prescale = 0, periodic on ch3 while ch0 runs as in REQ-028 -> pulse[3] is constantly 1 and the ch0 period is unchanged.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel timer.
// Holds ctrl mode values and write-select codes.
package timer_pkg;

  localparam logic [1:0] MODE_PERIODIC = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;

  localparam logic [1:0] SEL_LIMIT    = 2'd0;
  localparam logic [1:0] SEL_PRESCALE = 2'd1;
  localparam logic [1:0] SEL_CTRL     = 2'd2;
  localparam logic [1:0] SEL_IGNORE   = 2'd3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: config regs, prescaler, counter, pulse/irq.
// Ports: clk, reset, we_i/sel_i/data_i (write), ack_i, pulse_o, irq_o, en_o.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [1:0]       sel_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             ack_i,
  output logic             pulse_o,
  output logic             irq_o,
  output logic             en_o
);

  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pscl_q, pscl_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             pulse_q, pulse_d;
  logic             irq_q, irq_d;
  logic             en, square, oneshot;
  logic             tick, term;

  always_comb begin
    en      = ctrl_q[0];
    square  = (ctrl_q[2:1] == MODE_SQUARE);
    oneshot = (ctrl_q[2:1] == MODE_ONESHOT);
    tick    = en && !we_i && (pre_q == pscl_q);
    term    = tick && (cnt_q >= limit_q);

    limit_d = limit_q;
    pscl_d  = pscl_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    pulse_d = pulse_q;

    if (we_i) begin
      case (sel_i)
        SEL_LIMIT:    limit_d = data_i;
        SEL_PRESCALE: pscl_d  = PRE_W'(data_i);
        SEL_CTRL:     ctrl_d  = 3'(data_i);
        default:      ;
      endcase
      cnt_d   = '0;
      pre_d   = '0;
      pulse_d = 1'b0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick) begin
        cnt_d = term ? '0 : cnt_q + CNT_W'(1);
      end
      pulse_d = square ? (pulse_q ^ term) : term;
      if (term && oneshot) begin
        ctrl_d[0] = 1'b0;
      end
    end else if (!square) begin
      pulse_d = 1'b0;
    end

    // a new terminal event beats a same-cycle ack
    irq_d = term | (irq_q & ~ack_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q <= '1;
      pscl_q  <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      pulse_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      pscl_q  <= pscl_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
      irq_q   <= irq_d;
    end
  end

  assign pulse_o = pulse_q;
  assign irq_o   = irq_q;
  assign en_o    = ctrl_q[0];

endmodule

// File: rtl/multi_timer.sv
// N_CH independent prescaled timers sharing one write port.
// Ports: clk, reset, wr_en/wr_ch/wr_sel/wr_data, ack, pulse, irq, en_out.
module multi_timer
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       wr_sel,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [N_CH-1:0]  ack,
  output logic [N_CH-1:0]  pulse,
  output logic [N_CH-1:0]  irq,
  output logic [N_CH-1:0]  en_out
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;

    // out-of-range channels never match; sel 3 is not a register
    assign hit = wr_en
              && (wr_sel != SEL_IGNORE)
              && (wr_ch == CH_W'(i));

    timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .we_i   (hit),
      .sel_i  (wr_sel),
      .data_i (wr_data),
      .ack_i  (ack[i]),
      .pulse_o(pulse[i]),
      .irq_o  (irq[i]),
      .en_o   (en_out[i])
    );
  end

endmodule
